// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the IF-stage SRAM-like fetch port to an AXI read channel.
// Optional INST_BRIDGE_RRESP_CHECK_EN raises bus_err on delivered non-OKAY responses.
module inst_axi_bridge #(
  parameter logic [3:0]  AR_ID    = 4'd0,
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        flush,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;

  localparam logic [1:0] OUTS_LIMIT = 2'(MAX_OUTS);

  ar_state_t  state, state_nxt;
  logic [1:0] outs_cnt, drop_cnt;
  logic       accept, r_hs, r_retire;

  assign arid    = AR_ID;
  assign arlen   = '0;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign rready  = 1'b1;

  assign r_hs     = rvalid && rready;
  assign r_retire = r_hs && (outs_cnt != '0);
  assign accept   = !reset && (state == AR_IDLE) && inst_sram_req && !flush &&
                    (outs_cnt < OUTS_LIMIT);

  assign inst_sram_addr_ok = accept;
  assign inst_sram_rdata   = rdata;
  // A beat with nothing outstanding (e.g. left over from before a reset) is never delivered.
  assign inst_sram_data_ok = !reset && r_retire && (drop_cnt == '0) && !flush;

  always_ff @(posedge clk) begin
    if (reset) state <= AR_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    case (state)
      AR_IDLE: if (accept) state_nxt = AR_SEND;
      AR_SEND: begin
        arvalid = 1'b1;
        if (arready) state_nxt = AR_IDLE;
      end
      default: state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr <= '0;
      arsize <= '0;
    end else if (accept) begin
      araddr <= inst_sram_addr;
      arsize <= {1'b0, inst_sram_size};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outs_cnt <= '0;
    end else begin
      case ({accept, r_retire})
        2'b10:   outs_cnt <= outs_cnt + 2'd1;
        2'b01:   outs_cnt <= outs_cnt - 2'd1;
        default: outs_cnt <= outs_cnt;
      endcase
    end
  end

  // On flush every outstanding fetch is stale; the beat retiring this cycle is already gone.
  always_ff @(posedge clk) begin
    if (reset)                            drop_cnt <= '0;
    else if (flush)                       drop_cnt <= r_retire ? outs_cnt - 2'd1 : outs_cnt;
    else if (r_hs && (drop_cnt != '0))    drop_cnt <= drop_cnt - 2'd1;
  end

`ifdef INST_BRIDGE_RRESP_CHECK_EN
  assign bus_err = inst_sram_data_ok && (rresp != 2'b00);
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};
`else
  assign bus_err = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast, rresp};
`endif

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Scoreboard bench for inst_axi_bridge: directed fetches, flushes, error response, reset.
module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic        flush;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, bus_err;

`ifdef INST_BRIDGE_RRESP_CHECK_EN
  localparam bit ERR_CHK = 1'b1;
`else
  localparam bit ERR_CHK = 1'b0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [34:0] ar_q[$];
  logic [32:0] r_q[$];

  always #5 clk = ~clk;

  inst_axi_bridge #(.AR_ID(4'd0), .MAX_OUTS(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .flush(flush),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an AR handshake or data_ok.
  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid && arready) begin
        vectors++;
        if (ar_q.size() == 0) begin
          miscompares++;
          $display("FAIL ar_unexpected: got araddr %0h, expected none", araddr);
        end else begin
          logic [34:0] e;
          e = ar_q.pop_front();
          if ({araddr, arsize} !== e) begin
            miscompares++;
            $display("FAIL ar_addr: got %0h expected %0h", {araddr, arsize}, e);
          end
        end
      end
      if (data_ok) begin
        vectors++;
        if (r_q.size() == 0) begin
          miscompares++;
          $display("FAIL data_ok_unexpected: got rdata %0h, expected no data_ok", sram_rdata);
        end else begin
          logic [32:0] e;
          e = r_q.pop_front();
          if ({bus_err, sram_rdata} !== e) begin
            miscompares++;
            $display("FAIL rdata: got err/data %0h expected %0h", {bus_err, sram_rdata}, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] sz);
    int unsigned n = 0;
    req = 1'b1; addr = a; size = sz;
    @(negedge clk);
    while (!addr_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!addr_ok) begin
      miscompares++;
      $display("FAIL addr_ok_timeout: got no addr_ok for %0h, expected addr_ok", a);
    end else begin
      ar_q.push_back({a, 1'b0, sz});
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_ar_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (arvalid) begin
      vectors++;
      miscompares++;
      $display("FAIL ar_timeout: got arvalid stuck 1, expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input bit deliver);
    rvalid = 1'b1; rdata = d; rresp = resp;
    if (deliver) r_q.push_back({ERR_CHK && (resp != 2'b00), d});
    tick();
    rvalid = 1'b0; rresp = 2'b00;
  endtask

  initial begin
    reset = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; wstrb = '0; addr = 32'h1234_5678;
    wdata = '0; flush = 1'b0; arready = 1'b0; rid = '0; rdata = 32'hdead_beef;
    rresp = 2'b10; rlast = 1'b1; rvalid = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset_arvalid", 35'(arvalid), 35'd0);
    chk("reset_araddr", {araddr, arsize}, 35'd0);
    chk("reset_addr_ok", 35'(addr_ok), 35'd0);
    chk("reset_data_ok", 35'(data_ok), 35'd0);
    chk("reset_bus_err", 35'(bus_err), 35'd0);
    chk("const_ar", {arid, arlen, arburst, arlock, arcache, arprot, rready},
        {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
    @(posedge clk); #1;
    req = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    reset = 1'b0;
    tick();

    // Single fetch, arready on the second AR_SEND cycle.
    do_req(32'hbfc0_0000, 2'd2);
    @(negedge clk);
    chk("ar_send_arvalid", 35'(arvalid), 35'd1);
    @(posedge clk); #1;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    tick(); tick();
    beat(32'h3c08_0001, 2'b00, 1'b1);
    tick();

    // Back-to-back: third request held off until the first response retires.
    arready = 1'b1;
    do_req(32'hbfc0_0004, 2'd2);
    do_req(32'hbfc0_0008, 2'd2);
    req = 1'b1; addr = 32'hbfc0_000c; size = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("max_outs_hold", 35'(addr_ok), 35'd0);
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rdata = 32'h0000_0004; rresp = 2'b00;
    r_q.push_back({1'b0, 32'h0000_0004});
    @(negedge clk);
    chk("max_outs_hold_rv", 35'(addr_ok), 35'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    do_req(32'hbfc0_000c, 2'd2);
    wait_ar_idle();
    beat(32'h0000_0008, 2'b00, 1'b1);
    beat(32'h0000_000c, 2'b00, 1'b1);
    tick();

    // Flush with two outstanding and no response in the flush cycle.
    do_req(32'hbfc0_0100, 2'd2);
    do_req(32'hbfc0_0104, 2'd2);
    wait_ar_idle();
    flush = 1'b1; req = 1'b1; addr = 32'hbfc0_0380;
    @(negedge clk);
    chk("flush_addr_ok", 35'(addr_ok), 35'd0);
    @(posedge clk); #1;
    flush = 1'b0; req = 1'b0;
    beat(32'h1111_1111, 2'b00, 1'b0);
    beat(32'h2222_2222, 2'b00, 1'b0);
    do_req(32'hbfc0_0380, 2'd2);
    wait_ar_idle();
    beat(32'h4000_6800, 2'b00, 1'b1);
    tick();

    // Flush coincident with a response: that beat and exactly one more are dropped.
    do_req(32'hbfc0_0200, 2'd2);
    do_req(32'hbfc0_0204, 2'd2);
    wait_ar_idle();
    flush = 1'b1; rvalid = 1'b1; rdata = 32'h3333_3333;
    @(negedge clk);
    chk("flush_rv_data_ok", 35'(data_ok), 35'd0);
    @(posedge clk); #1;
    flush = 1'b0; rvalid = 1'b0;
    beat(32'h4444_4444, 2'b00, 1'b0);
    do_req(32'hbfc0_0208, 2'd2);
    wait_ar_idle();
    beat(32'h5555_5555, 2'b00, 1'b1);
    tick();

    // Error response, with an OKAY response after it.
    do_req(32'hbfc0_0300, 2'd1);
    wait_ar_idle();
    beat(32'h6666_6666, 2'b10, 1'b1);
    do_req(32'hbfc0_0304, 2'd0);
    wait_ar_idle();
    beat(32'h7777_7777, 2'b00, 1'b1);
    tick();

    // Reset while in AR_SEND.
    arready = 1'b0;
    do_req(32'hbfc0_0400, 2'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    ar_q.delete();
    req = 1'b1; rvalid = 1'b1; rdata = 32'h8888_8888;
    @(negedge clk);
    chk("rst_mid_arvalid", 35'(arvalid), 35'd0);
    chk("rst_mid_araddr", {araddr, arsize}, 35'd0);
    chk("rst_mid_addr_ok", 35'(addr_ok), 35'd0);
    chk("rst_mid_data_ok", 35'(data_ok), 35'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    tick();
    rvalid = 1'b0;
    arready = 1'b1;
    do_req(32'hbfc0_0500, 2'd2);
    do_req(32'hbfc0_0504, 2'd2);
    wait_ar_idle();
    beat(32'h9999_0000, 2'b00, 1'b1);
    beat(32'h9999_0004, 2'b00, 1'b1);
    tick(); tick();

    chk("ar_q_drained", 35'(ar_q.size()), 35'd0);
    chk("r_q_drained", 35'(r_q.size()), 35'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
